// File: rtl/graph_mem_responder_if.sv
// Read request/response and host load bus of the graph memory responder.
interface graph_mem_responder_if;
   logic [31:0] mem_addr;
   logic        mem_rd_en;
   logic [31:0] mem_data;
   logic        mem_valid;
   logic        ld_en;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;

   // Requester side: issues reads and host loads, receives read data.
   modport master (
      output mem_addr, mem_rd_en, ld_en, ld_addr, ld_data,
      input  mem_data, mem_valid
   );

   // Responder side: owns the memory and returns read data.
   modport slave (
      input  mem_addr, mem_rd_en, ld_en, ld_addr, ld_data,
      output mem_data, mem_valid
   );
endinterface

// File: rtl/graph_mem_responder.sv
// Graph node memory: fixed-latency in-order reads, host word loads and a
// one-word-per-cycle background clear.
module graph_mem_responder #(
   parameter int unsigned NUM_NODES    = 32,
   parameter int unsigned READ_LATENCY = 2,
   parameter logic [31:0] ERR_WORD     = 32'hDEAD_BEEF
) (
   input  logic                  clk,
   input  logic                  rst,
   graph_mem_responder_if.slave  bus,
   input  logic                  clr_start,
   output logic                  clr_busy,
   output logic                  err_sticky,
   output logic [31:0]           reads_served,
   output logic [3:0]            outstanding
);

   localparam int unsigned DEPTH = NUM_NODES * 32;
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t          state, state_nxt;
   logic [AW-1:0]   clr_idx, clr_idx_nxt;
   logic            clr_we;

   logic [31:0]     mem [DEPTH];

   logic [29:0]     rd_word;
   logic            rd_legal;
   logic [31:0]     rd_word_data;
   logic            ld_ok;

   logic [READ_LATENCY-1:0] pipe_vld;
   logic [31:0]             pipe_data [READ_LATENCY];
   logic                    ret;

   // Request decode; memory is read combinationally so a same-cycle load is not seen.
   assign rd_word      = bus.mem_addr[31:2];
   assign rd_legal     = (bus.mem_addr[1:0] == 2'b00) && (32'(rd_word) < DEPTH);
   assign rd_word_data = rd_legal ? mem[rd_word[AW-1:0]] : ERR_WORD;
   assign ld_ok        = bus.ld_en && (bus.ld_addr < DEPTH) && (state == IDLE);
   assign ret          = pipe_vld[READ_LATENCY-1];

   // Clear FSM next-state: walk every word once, then return to IDLE.
   always_comb begin
      state_nxt   = state;
      clr_idx_nxt = clr_idx;
      clr_we      = 1'b0;
      case (state)
         IDLE: begin
            if (clr_start) begin
               state_nxt   = CLEAR;
               clr_idx_nxt = '0;
            end
         end
         CLEAR: begin
            clr_we = 1'b1;
            if (clr_idx == AW'(DEPTH - 1)) begin
               state_nxt = IDLE;
            end else begin
               clr_idx_nxt = clr_idx + AW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Clear FSM state register; clr_busy tracks the registered state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         clr_idx  <= '0;
         clr_busy <= 1'b0;
      end else begin
         state    <= state_nxt;
         clr_idx  <= clr_idx_nxt;
         clr_busy <= (state_nxt == CLEAR);
      end
   end

   // Memory write port; contents survive reset, but a reset cycle writes nothing.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (clr_we) begin
            mem[clr_idx] <= '0;
         end else if (ld_ok) begin
            mem[bus.ld_addr[AW-1:0]] <= bus.ld_data;
         end
      end
   end

   // Read response shift pipeline; reset flushes in-flight reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_vld <= '0;
      end else begin
         pipe_vld[0]  <= bus.mem_rd_en;
         pipe_data[0] <= rd_word_data;
         for (int i = 1; i < int'(READ_LATENCY); i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_data[i] <= pipe_data[i-1];
         end
      end
   end

   // Response outputs and status counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.mem_valid <= 1'b0;
         bus.mem_data  <= '0;
         reads_served  <= '0;
         outstanding   <= '0;
         err_sticky    <= 1'b0;
      end else begin
         bus.mem_valid <= ret;
         if (ret) begin
            bus.mem_data <= pipe_data[READ_LATENCY-1];
         end
         reads_served <= reads_served + 32'(ret);
         outstanding  <= outstanding + 4'(bus.mem_rd_en) - 4'(ret);
         if (bus.mem_rd_en && !rd_legal) begin
            err_sticky <= 1'b1;
         end
      end
   end

endmodule
